// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Holds the output-buffer state encoding and the bit-counter width helper.
// Imported by the shift core and the top level.
package sipo_pkg;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Width of a counter able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter that assemble WIDTH serial bits into a word.
// Latency: word/done are combinational on the sample that completes the word.
// Backpressure: none; samples are always taken, the caller decides what to keep.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        sin,
  input  logic                        sin_en,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]            word,
  output logic                        done
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic             last_bit;

  // Next shift value; also the assembled word when this sample completes it.
  always_comb begin
    shift_nxt = shift_reg;
    if (MSB_FIRST) begin
      shift_nxt = {shift_reg[WIDTH-2:0], sin};
    end else begin
      shift_nxt = {sin, shift_reg[WIDTH-1:1]};
    end
  end

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  // clr drops the concurrent sample, so it also suppresses completion.
  assign done     = sin_en & ~clr & last_bit;
  assign word     = shift_nxt;

  // Shift and count on each qualified sample; the counter wraps with no idle cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (sin_en) begin
      shift_reg <= shift_nxt;
      bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a one-entry valid/ready output buffer.
// Latency: word visible on out_data/out_valid the cycle after its WIDTH-th sample.
// Backpressure: a word completing while the buffer is held is dropped and flags sticky overrun.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        sin,
  input  logic                        sin_en,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overrun,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  buf_state_t       state;
  buf_state_t       state_nxt;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             load;
  logic             ovr_set;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .sin     (sin),
    .sin_en  (sin_en),
    .bit_cnt (bit_cnt),
    .word    (word),
    .done    (done)
  );

  // Buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Buffer next state: load on completion unless the held word is still unconsumed.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (out_ready) begin
          if (done) begin
            load = 1'b1;
          end else begin
            state_nxt = BUF_EMPTY;
          end
        end else if (done) begin
          ovr_set = 1'b1;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  assign out_valid = (state == BUF_FULL);

  // Output word register; held stable while the buffer is full and not consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= word;
    end
  end

  // Sticky overrun; only clr or reset clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          sin;
  logic          sin_en;
  logic          out_ready;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l;
  logic          ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .clr(clr), .sin(sin), .sin_en(sin_en),
    .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .clr(clr), .sin(sin), .sin_en(sin_en),
    .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  // Reference model: list of bits received so far plus a one-word buffer.
  bit           q[$];
  logic         m_valid;
  logic [W-1:0] m_data_m, m_data_l;
  logic         m_ovr;

  task automatic model_reset();
    q.delete();
    m_valid  = 1'b0;
    m_data_m = '0;
    m_data_l = '0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic en, input logic rdy, input logic c);
    logic         complete;
    logic [W-1:0] wm, wl;
    complete = 1'b0;
    wm = '0;
    wl = '0;
    if (c) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (en) begin
      q.push_back(b);
      if (q.size() == W) begin
        complete = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        q.delete();
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_valid  = 1'b1;
        m_data_m = wm;
        m_data_l = wl;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick(input logic b, input logic en, input logic rdy, input logic c);
    sin       = b;
    sin_en    = en;
    out_ready = rdy;
    clr       = c;
    @(posedge clk);
    model_step(b, en, rdy, c);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy);
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b1, rdy, 1'b0);
  endtask

  task automatic test_reset();
    sin = 0; sin_en = 0; out_ready = 0; clr = 0;
    reset = 1'b1;
    #2;
    checks++;
    if (data_m !== 8'h00 || valid_m !== 1'b0 || ovr_m !== 1'b0 || cnt_m !== '0) begin
      failures++;
      $display("FAIL reset_state: data=%h valid=%b ovr=%b cnt=%0d required 00/0/0/0",
               data_m, valid_m, ovr_m, cnt_m);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_msb_lsb();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      tick(pat[i], 1'b1, 1'b1, 1'b0);
      if (i == 1) begin
        checks++;
        if (valid_m !== 1'b0 || cnt_m !== CW'(7)) begin
          failures++;
          $display("FAIL pre_complete: valid=%b cnt=%0d required 0/7", valid_m, cnt_m);
        end
      end
    end
    checks++;
    if (data_m !== 8'hB2 || valid_m !== 1'b1 || cnt_m !== '0) begin
      failures++;
      $display("FAIL msb_first: data=%h valid=%b cnt=%0d required b2/1/0", data_m, valid_m, cnt_m);
    end
    checks++;
    if (data_l !== 8'h4D || valid_l !== 1'b1) begin
      failures++;
      $display("FAIL lsb_first: data=%h valid=%b required 4d/1", data_l, valid_l);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (valid_m !== 1'b0 || valid_l !== 1'b0) begin
      failures++;
      $display("FAIL consume: valid_m=%b valid_l=%b required 0/0", valid_m, valid_l);
    end
  endtask

  task automatic test_overrun();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    checks++;
    if (data_m !== 8'hA5 || ovr_m !== 1'b1 || valid_m !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold: data=%h ovr=%b valid=%b required a5/1/1", data_m, ovr_m, valid_m);
    end
    checks++;
    if (data_l !== m_data_l || ovr_l !== 1'b1) begin
      failures++;
      $display("FAIL overrun_lsb: data=%h ovr=%b required %h/1", data_l, ovr_l, m_data_l);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (valid_m !== 1'b0 || ovr_m !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: valid=%b ovr=%b required 0/1", valid_m, ovr_m);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr: ovr_m=%b ovr_l=%b required 0/0", ovr_m, ovr_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    send_byte(8'h11, 1'b0);
    checks++;
    if (data_m !== 8'h11 || valid_m !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: data=%h valid=%b required 11/1", data_m, valid_m);
    end
    v = 8'h22;
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b1, (i == 0), 1'b0);
    checks++;
    if (data_m !== 8'h22 || valid_m !== 1'b1 || ovr_m !== 1'b0) begin
      failures++;
      $display("FAIL b2b_same_edge: data=%h valid=%b ovr=%b required 22/1/0", data_m, valid_m, ovr_m);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_gapped();
    logic [7:0] v;
    v = 8'hF0;
    for (int i = 7; i >= 0; i--) begin
      tick(v[i], 1'b1, 1'b0, 1'b0);
      if (i != 0) begin
        tick(~v[i], 1'b0, 1'b0, 1'b0);
        tick(~v[i], 1'b0, 1'b0, 1'b0);
        checks++;
        if (cnt_m !== CW'(8 - i)) begin
          failures++;
          $display("FAIL gap_hold: cnt=%0d required %0d", cnt_m, 8 - i);
        end
      end
    end
    checks++;
    if (data_m !== 8'hF0 || valid_m !== 1'b1 || cnt_m !== '0) begin
      failures++;
      $display("FAIL gapped_word: data=%h valid=%b cnt=%0d required f0/1/0", data_m, valid_m, cnt_m);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clr_partial();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt_m !== '0 || valid_m !== 1'b0) begin
      failures++;
      $display("FAIL clr_count: cnt=%0d valid=%b required 0/0", cnt_m, valid_m);
    end
    send_byte(8'h81, 1'b0);
    checks++;
    if (data_m !== 8'h81 || valid_m !== 1'b1) begin
      failures++;
      $display("FAIL clr_fresh: data=%h valid=%b required 81/1", data_m, valid_m);
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (valid_m !== 1'b0 || data_m !== 8'h00 || cnt_m !== '0 || valid_l !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b data=%h cnt=%0d required 0/00/0", valid_m, data_m, cnt_m);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int errs;
    logic b, en, rdy, c;
    errs = 0;
    for (int n = 0; n < 500; n++) begin
      b   = 1'($urandom);
      en  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 4);
      c   = ($urandom_range(0, 99) < 3);
      tick(b, en, rdy, c);
      checks++;
      if (data_m !== m_data_m || data_l !== m_data_l || valid_m !== m_valid ||
          valid_l !== m_valid || ovr_m !== m_ovr || ovr_l !== m_ovr ||
          cnt_m !== CW'(q.size()) || cnt_l !== CW'(q.size())) begin
        failures++;
        if (errs < 10)
          $display("FAIL random[%0d]: dm=%h dl=%h v=%b%b o=%b%b c=%0d required dm=%h dl=%h v=%b o=%b c=%0d",
                   n, data_m, data_l, valid_m, valid_l, ovr_m, ovr_l, cnt_m,
                   m_data_m, m_data_l, m_valid, m_ovr, q.size());
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_overrun();
    test_back_to_back();
    test_gapped();
    test_clr_partial();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
